svv_push_arbiter: RTL and testbench



---
 rtl/svv_push_arbiter.sv | 134 +++++++++++++
 tb/tb_svv_push_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svv_push_arbiter.sv
// Round-robin push arbiter in front of a shared status_value_vector: NREQ producers
// push {id, data} entries, one consumer pulls them, and a flush drains the vector.
module svv_push_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int IDW   = $clog2(NREQ),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [IDW-1:0]        out_id_o,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic [CW-1:0]         count_o,
  output logic                  err_o,
  output logic                  vec_push_o,
  output logic                  vec_pull_o,
  output logic [WIDTH+IDW-1:0]  vec_value_o,
  input  logic [WIDTH+IDW-1:0]  vec_value_i,
  input  logic                  vec_valid_i,
  input  logic                  vec_full_i
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e           state;
  logic [IDW-1:0]   ptr;
  logic             in_run;
  logic             pull;
  logic             push_ok;
  logic             found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     cand;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] req_data_a [NREQ];
  logic             cons_err;
  logic             sat_err;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_data_a[i] = req_data_i[i*WIDTH +: WIDTH];
    end
  end

  assign in_run      = (state == ST_RUN);
  assign out_valid_o = in_run & vec_valid_i;

  // While flushing every valid entry is pulled and discarded, regardless of the consumer.
  assign pull    = ~rst_i & vec_valid_i & (in_run ? out_ready_i : 1'b1);
  assign push_ok = ~rst_i & in_run & ~flush_i & (~vec_full_i | pull);

  // NOTE: every signal gets a default at the top of an always_comb so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (push_ok && !found && req_valid_i[cand[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
    grant = found ? (NREQ'(1) << grant_idx) : '0;
  end

  assign req_ready_o = grant;
  assign vec_push_o  = found;
  assign vec_pull_o  = pull;
  // With no grant grant_idx is zero, so the idle value is {0, slice 0}.
  assign vec_value_o = {grant_idx, req_data_a[grant_idx]};

  assign out_data_o = vec_value_i[WIDTH-1:0];
  assign out_id_o   = vec_value_i[WIDTH+IDW-1:WIDTH];

  assign cons_err = ((count_o != '0) != vec_valid_i) |
                    ((count_o == CW'(DEPTH)) != vec_full_i);
  assign sat_err  = (found & ~pull & (count_o == CW'(DEPTH))) |
                    (pull & ~found & (count_o == '0));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_RUN;
      ptr          <= '0;
      count_o      <= '0;
      err_o        <= 1'b0;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      case (state)
        ST_RUN: begin
          if (flush_i) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (!vec_valid_i) begin
            state        <= ST_RUN;
            flush_done_o <= 1'b1;
          end
        end
      endcase

      if (found) begin
        ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end

      if (found && !pull && (count_o != CW'(DEPTH))) begin
        count_o <= count_o + CW'(1);
      end else if (pull && !found && (count_o != '0)) begin
        count_o <= count_o - CW'(1);
      end

      if (cons_err || sat_err) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svv_push_arbiter.sv
// Randomized bench for svv_push_arbiter: a queue-based vector stands in for
// status_value_vector and a transaction-level model predicts every DUT output.
module tb_svv_push_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int IDW   = 2;
  localparam int CW    = 7;
  localparam int VW    = WIDTH + IDW;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*WIDTH-1:0] req_data_i;
  logic [NREQ-1:0]       req_ready_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [WIDTH-1:0]      out_data_o;
  logic [IDW-1:0]        out_id_o;
  logic                  flush_i;
  logic                  flush_done_o;
  logic [CW-1:0]         count_o;
  logic                  err_o;
  logic                  vec_push_o;
  logic                  vec_pull_o;
  logic [VW-1:0]         vec_value_o;
  logic [VW-1:0]         vec_value_i;
  logic                  vec_valid_i;
  logic                  vec_full_i;

  svv_push_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_id_o(out_id_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .count_o(count_o), .err_o(err_o),
    .vec_push_o(vec_push_o), .vec_pull_o(vec_pull_o), .vec_value_o(vec_value_o),
    .vec_value_i(vec_value_i), .vec_valid_i(vec_valid_i), .vec_full_i(vec_full_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Stand-in vector (harness) and its fault-injection override.
  logic [VW-1:0] vq[$];
  bit            force_valid = 1'b0;

  // Reference model state.
  bit            m_run   = 1'b1;
  int            m_ptr   = 0;
  int            m_count = 0;
  bit            m_err   = 1'b0;
  bit            m_done  = 1'b0;
  logic [VW-1:0] m_fifo[$];

  logic [NREQ-1:0] last_grant;
  bit              last_pull;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic env_drive();
    vec_valid_i = (vq.size() > 0) || force_valid;
    vec_full_i  = (vq.size() == DEPTH);
    vec_value_i = (vq.size() > 0) ? vq[0] : '0;
  endtask

  task automatic set_idle();
    rst_i       = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  // One clock cycle: predict and check combinational outputs, clock the edge,
  // advance vector and model, then check registered outputs.
  task automatic tick();
    logic [NREQ-1:0] eg;
    logic [VW-1:0]   ev, head, dv;
    bit              pl, el, vv, vf, dp, dl, push;
    int              win;
    #2;
    vv = vec_valid_i;
    vf = vec_full_i;
    eg = '0;
    ev = {{IDW{1'b0}}, req_data_i[WIDTH-1:0]};
    pl = 1'b0;
    win = -1;
    if (!rst_i) begin
      pl = vv && (m_run ? out_ready_i : 1'b1);
      el = m_run && !flush_i && (!vf || pl);
      if (el) begin
        for (int k = 0; k < NREQ; k++) begin
          int gi;
          gi = (m_ptr + k) % NREQ;
          if (req_valid_i[gi]) begin
            win = gi;
            eg[gi] = 1'b1;
            ev = {IDW'(gi), req_data_i[gi*WIDTH +: WIDTH]};
            break;
          end
        end
      end
    end
    push = (win >= 0);
    check("req_ready", req_ready_o, eg);
    check("vec_push", vec_push_o, push);
    check("vec_pull", vec_pull_o, pl);
    check("vec_value", vec_value_o, ev);
    check("out_valid", out_valid_o, m_run && vv);
    check("out_data", out_data_o, vec_value_i[WIDTH-1:0]);
    check("out_id", out_id_o, vec_value_i[VW-1:WIDTH]);
    if (!rst_i && m_run && pl && m_fifo.size() > 0) begin
      head = m_fifo[0];
      check("sb_id", out_id_o, head[VW-1:WIDTH]);
      check("sb_data", out_data_o, head[WIDTH-1:0]);
    end
    last_grant = req_ready_o;
    last_pull  = vec_pull_o;
    dp = vec_push_o;
    dl = vec_pull_o;
    dv = vec_value_o;

    @(posedge clk_i);
    #1;
    if (rst_i) begin
      vq.delete();
      m_fifo.delete();
      m_run = 1'b1; m_ptr = 0; m_count = 0; m_err = 1'b0; m_done = 1'b0;
    end else begin
      if (dl && vq.size() > 0) void'(vq.pop_front());
      if (dp && vq.size() < DEPTH) vq.push_back(dv);

      if (((m_count != 0) != vv) || ((m_count == DEPTH) != vf)) m_err = 1'b1;
      if (push && !pl) begin
        if (m_count == DEPTH) m_err = 1'b1; else m_count++;
      end else if (pl && !push) begin
        if (m_count == 0) m_err = 1'b1; else m_count--;
      end
      m_done = !m_run && !vv;
      if (m_run && flush_i) m_run = 1'b0;
      else if (!m_run && !vv) m_run = 1'b1;
      if (push) m_ptr = (win + 1) % NREQ;
      if (pl && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (push) m_fifo.push_back(ev);
    end
    env_drive();
    #1;
    check("count", count_o, m_count);
    check("err", err_o, m_err);
    check("flush_done", flush_done_o, m_done);
  endtask

  task automatic do_reset(int n);
    rst_i = 1'b1;
    repeat (n) tick();
    rst_i = 1'b0;
  endtask

  task automatic rand_reqs();
    req_valid_i = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    req_data_i  = {$urandom, $urandom};
  endtask

  // Pulses flush_i for one cycle, then counts cycles until flush_done_o.
  task automatic run_flush(input bit producers, output int lat, output int pulls,
                           output int grants);
    flush_i = 1'b1;
    if (producers) rand_reqs();
    tick();
    flush_i = 1'b0;
    lat = 0; pulls = 0; grants = 0;
    while (!flush_done_o && lat < 40) begin
      if (producers) rand_reqs();
      tick();
      lat++;
      pulls  += int'(last_pull);
      grants += int'(|last_grant);
    end
  endtask

  initial begin
    int lat, pulls, grants;
    logic [NREQ-1:0] exp_g;
    set_idle();
    env_drive();
    @(posedge clk_i);
    #1;
    do_reset(2);

    // Idle after reset, then one push from requester 2.
    tick();
    check("idle_count", count_o, 0);
    check("idle_valid", out_valid_o, 0);
    req_valid_i = 4'b0100;
    req_data_i  = 32'h005A_0000;
    tick();
    check("single_grant", last_grant, 4'b0100);
    req_valid_i = '0;
    check("single_valid", out_valid_o, 1);
    check("single_id", out_id_o, 2);
    check("single_data", out_data_o, 8'h5A);

    // Round-robin across all requesters, then read back in order.
    do_reset(1);
    req_valid_i = '1;
    for (int c = 0; c < 8; c++) begin
      req_data_i = {$urandom};
      tick();
      exp_g = 4'b0001 << (c % NREQ);
      check("rr_grant", last_grant, exp_g);
    end
    check("rr_count", count_o, 8);
    req_valid_i = '0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check("rr_read_id", out_id_o, c % NREQ);
      tick();
    end
    check("rr_drained", count_o, 0);

    // Fill to DEPTH, hold, then swap on full.
    do_reset(1);
    out_ready_i = 1'b0;
    for (int c = 0; c < 200 && count_o != CW'(DEPTH); c++) begin
      rand_reqs();
      tick();
    end
    check("fill_count", count_o, DEPTH);
    req_valid_i = '1;
    repeat (3) begin
      tick();
      check("full_no_grant", last_grant, 0);
    end
    out_ready_i = 1'b1;
    repeat (5) begin
      rand_reqs();
      tick();
      check("full_swap_push", |last_grant, 1);
      check("full_swap_pull", last_pull, 1);
      check("full_swap_count", count_o, DEPTH);
    end
    check("full_err", err_o, 0);

    // Flush ten queued entries with producers still requesting.
    do_reset(1);
    out_ready_i = 1'b0;
    repeat (10) begin
      rand_reqs();
      tick();
    end
    check("pre_flush_count", count_o, 10);
    run_flush(1'b1, lat, pulls, grants);
    check("flush10_latency", lat, 11);
    check("flush10_pulls", pulls, 10);
    check("flush10_grants", grants, 0);
    check("flush10_count", count_o, 0);
    req_valid_i = '0;
    tick();

    // Flush of an empty vector, then confirm the FSM accepts pushes again.
    run_flush(1'b0, lat, pulls, grants);
    check("flush0_latency", lat, 1);
    req_valid_i = 4'b0001;
    tick();
    check("flush0_run", last_grant, 4'b0001);
    req_valid_i = '0;

    // Randomized traffic with occasional flushes and resets.
    for (int e = 0; e < 10; e++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(5, 95);
      for (int c = 0; c < 300; c++) begin
        rst_i       = ($urandom_range(0, 299) == 0);
        req_valid_i = NREQ'($urandom);
        req_data_i  = {$urandom};
        out_ready_i = ($urandom_range(0, 99) < rdy_pct);
        flush_i     = ($urandom_range(0, 79) == 0);
        tick();
      end
    end
    set_idle();

    // Inconsistent vector status must latch err_o until reset.
    do_reset(1);
    force_valid = 1'b1;
    env_drive();
    tick();
    check("err_rise", err_o, 1);
    force_valid = 1'b0;
    env_drive();
    repeat (3) tick();
    check("err_sticky", err_o, 1);
    do_reset(1);
    check("err_cleared", err_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
